mem2_load_align: RTL and testbench

Parametrised successor to the MEM2 writeback-side stage. It takes raw data-SRAM read beats from MEM1, then selects, merges and zero/sign-extends the load result. It supports XLEN 32 or 64 and loads that cross an XLEN/8 boundary, delivered as two beats. It replaces the stall-bus pipeline register with a valid/ready handshake and drives the writeback bus plus the ID forwarding and load-pending signals.

---
 rtl/mem2_load_align.sv | 218 +++++++++++++++++++++
 tb/tb_mem2_load_align.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem2_load_align.sv
// mem2_load_align: writeback-side load alignment stage.
//
// Takes raw data-SRAM read beats from MEM1, extracts the addressed bytes,
// merges the two beats of a load that crosses an XLEN/8 boundary, and
// zero/sign-extends the result into a single-entry writeback register.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   flush               drop buffered/incoming work, invalidate output
//   in_*                MEM1 beat with valid/ready handshake
//   out_*               writeback entry with valid/ready handshake
//   fwd_we/waddr/wdata  forwarding view of the writeback entry
//   fwd_pending*        a split load is waiting for its second beat
module mem2_load_align #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned RF_AW  = 5,
    parameter int unsigned INST_W = 32,
    parameter int unsigned OFS_W  = $clog2(XLEN / 8)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_rdata,
    input  logic [OFS_W-1:0]  in_offset,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic              in_is_load,
    input  logic              in_split,
    input  logic              in_rf_we,
    input  logic [RF_AW-1:0]  in_rf_waddr,
    input  logic [XLEN-1:0]   in_ex_result,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_rf_we,
    output logic [RF_AW-1:0]  out_rf_waddr,
    output logic [XLEN-1:0]   out_rf_wdata,
    output logic [XLEN-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic              fwd_we,
    output logic [RF_AW-1:0]  fwd_waddr,
    output logic [XLEN-1:0]   fwd_wdata,
    output logic              fwd_pending,
    output logic [RF_AW-1:0]  fwd_pending_waddr
);

    typedef enum logic {StIdle, StWaitHi} state_e;

    state_e state_q, state_d;

    // Lo-beat buffer for boundary-crossing loads
    logic [XLEN-1:0]   lo_data_q;
    logic [OFS_W-1:0]  lo_offset_q;
    logic [1:0]        lo_size_q;
    logic              lo_unsigned_q;
    logic              lo_rf_we_q;
    logic [RF_AW-1:0]  lo_rf_waddr_q;
    logic [XLEN-1:0]   lo_pc_q;
    logic [INST_W-1:0] lo_inst_q;

    // Writeback register
    logic              out_valid_q;
    logic              out_rf_we_q;
    logic [RF_AW-1:0]  out_rf_waddr_q;
    logic [XLEN-1:0]   out_rf_wdata_q;
    logic [XLEN-1:0]   out_pc_q;
    logic [INST_W-1:0] out_inst_q;

    logic accept;
    logic hi_beat;
    logic start_split;

    assign in_ready    = !out_valid_q || out_ready;
    assign accept      = in_valid && in_ready && !flush;
    assign hi_beat     = (state_q == StWaitHi);
    // A split flag on a non-load is meaningless and ignored
    assign start_split = !hi_beat && in_is_load && in_split;

    // On the hi beat every field except rdata comes from the lo buffer
    logic [OFS_W-1:0]  sel_offset;
    logic [1:0]        sel_size;
    logic              sel_unsigned;
    logic              sel_is_load;
    logic              sel_rf_we;
    logic [RF_AW-1:0]  sel_rf_waddr;
    logic [XLEN-1:0]   sel_pc;
    logic [INST_W-1:0] sel_inst;
    logic [2*XLEN-1:0] window;

    assign sel_offset   = hi_beat ? lo_offset_q   : in_offset;
    assign sel_size     = hi_beat ? lo_size_q     : in_size;
    assign sel_unsigned = hi_beat ? lo_unsigned_q : in_unsigned;
    assign sel_is_load  = hi_beat ? 1'b1          : in_is_load;
    assign sel_rf_we    = hi_beat ? lo_rf_we_q    : in_rf_we;
    assign sel_rf_waddr = hi_beat ? lo_rf_waddr_q : in_rf_waddr;
    assign sel_pc       = hi_beat ? lo_pc_q       : in_pc;
    assign sel_inst     = hi_beat ? lo_inst_q     : in_inst;
    assign window       = hi_beat ? {in_rdata, lo_data_q} : {{XLEN{1'b0}}, in_rdata};

    // Byte extraction and extension
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic [1:0]      eff_size;
    logic            sign;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] wdata_d;

    assign shifted = XLEN'(window >> {sel_offset, 3'b000});

    always_comb begin
        eff_size = sel_size;
        // A doubleword on a 32-bit datapath collapses to a word
        if (XLEN == 32 && sel_size == 2'd3) eff_size = 2'd2;
        mask = '1;
        sign = shifted[XLEN-1];
        case (eff_size)
            2'd0: begin
                mask = XLEN'(8'hFF);
                sign = shifted[7];
            end
            2'd1: begin
                mask = XLEN'(16'hFFFF);
                sign = shifted[15];
            end
            2'd2: begin
                mask = XLEN'(32'hFFFF_FFFF);
                sign = shifted[31];
            end
            default: begin
                mask = '1;
                sign = shifted[XLEN-1];
            end
        endcase
        load_val = (shifted & mask) | ({XLEN{sign && !sel_unsigned}} & ~mask);
        wdata_d  = sel_is_load ? load_val : in_ex_result;
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StIdle;
        end else if (accept) begin
            state_d = start_split ? StWaitHi : StIdle;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            lo_data_q     <= '0;
            lo_offset_q   <= '0;
            lo_size_q     <= '0;
            lo_unsigned_q <= 1'b0;
            lo_rf_we_q    <= 1'b0;
            lo_rf_waddr_q <= '0;
            lo_pc_q       <= '0;
            lo_inst_q     <= '0;
        end else if (accept && start_split) begin
            lo_data_q     <= in_rdata;
            lo_offset_q   <= in_offset;
            lo_size_q     <= in_size;
            lo_unsigned_q <= in_unsigned;
            lo_rf_we_q    <= in_rf_we;
            lo_rf_waddr_q <= in_rf_waddr;
            lo_pc_q       <= in_pc;
            lo_inst_q     <= in_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            out_rf_we_q    <= 1'b0;
            out_rf_waddr_q <= '0;
            out_rf_wdata_q <= '0;
            out_pc_q       <= '0;
            out_inst_q     <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else begin
            if (out_ready) out_valid_q <= 1'b0;
            if (accept && !start_split) begin
                out_valid_q    <= 1'b1;
                out_rf_we_q    <= sel_rf_we && (sel_rf_waddr != '0);
                out_rf_waddr_q <= sel_rf_waddr;
                out_rf_wdata_q <= wdata_d;
                out_pc_q       <= sel_pc;
                out_inst_q     <= sel_inst;
            end
        end
    end

    // FSM: outputs
    always_comb begin
        out_valid         = out_valid_q;
        out_rf_we         = out_rf_we_q;
        out_rf_waddr      = out_rf_waddr_q;
        out_rf_wdata      = out_rf_wdata_q;
        out_pc            = out_pc_q;
        out_inst          = out_inst_q;
        fwd_we            = out_valid_q && out_rf_we_q;
        fwd_waddr         = out_rf_waddr_q;
        fwd_wdata         = out_rf_wdata_q;
        fwd_pending       = (state_q == StWaitHi);
        fwd_pending_waddr = (state_q == StWaitHi) ? lo_rf_waddr_q : '0;
    end

endmodule

// File: tb/tb_mem2_load_align.sv
module tb_mem2_load_align;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, flush, out_ready;

    // 64-bit instance
    logic        in_valid, in_ready, in_unsigned, in_is_load, in_split, in_rf_we;
    logic [63:0] in_rdata, in_ex_result, in_pc;
    logic [2:0]  in_offset;
    logic [1:0]  in_size;
    logic [4:0]  in_rf_waddr;
    logic [31:0] in_inst;
    logic        out_valid, out_rf_we, fwd_we, fwd_pending;
    logic [4:0]  out_rf_waddr, fwd_waddr, fwd_pending_waddr;
    logic [63:0] out_rf_wdata, out_pc, fwd_wdata;
    logic [31:0] out_inst;

    // 32-bit instance
    logic        n_in_valid, n_in_ready, n_in_unsigned, n_in_is_load, n_in_split, n_in_rf_we;
    logic [31:0] n_in_rdata, n_in_ex_result, n_in_pc, n_in_inst;
    logic [1:0]  n_in_offset, n_in_size;
    logic [4:0]  n_in_rf_waddr;
    logic        n_out_valid, n_out_rf_we, n_fwd_we, n_fwd_pending;
    logic [4:0]  n_out_rf_waddr, n_fwd_waddr, n_fwd_pending_waddr;
    logic [31:0] n_out_rf_wdata, n_out_pc, n_out_inst, n_fwd_wdata;

    mem2_load_align #(.XLEN(64)) u_wide (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_rdata(in_rdata),
        .in_offset(in_offset), .in_size(in_size), .in_unsigned(in_unsigned),
        .in_is_load(in_is_load), .in_split(in_split), .in_rf_we(in_rf_we),
        .in_rf_waddr(in_rf_waddr), .in_ex_result(in_ex_result), .in_pc(in_pc),
        .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
        .out_rf_we(out_rf_we), .out_rf_waddr(out_rf_waddr), .out_rf_wdata(out_rf_wdata),
        .out_pc(out_pc), .out_inst(out_inst), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
        .fwd_wdata(fwd_wdata), .fwd_pending(fwd_pending),
        .fwd_pending_waddr(fwd_pending_waddr)
    );

    mem2_load_align #(.XLEN(32)) u_narrow (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_rdata(n_in_rdata),
        .in_offset(n_in_offset), .in_size(n_in_size), .in_unsigned(n_in_unsigned),
        .in_is_load(n_in_is_load), .in_split(n_in_split), .in_rf_we(n_in_rf_we),
        .in_rf_waddr(n_in_rf_waddr), .in_ex_result(n_in_ex_result), .in_pc(n_in_pc),
        .in_inst(n_in_inst), .out_valid(n_out_valid), .out_ready(out_ready),
        .out_rf_we(n_out_rf_we), .out_rf_waddr(n_out_rf_waddr),
        .out_rf_wdata(n_out_rf_wdata), .out_pc(n_out_pc), .out_inst(n_out_inst),
        .fwd_we(n_fwd_we), .fwd_waddr(n_fwd_waddr), .fwd_wdata(n_fwd_wdata),
        .fwd_pending(n_fwd_pending), .fwd_pending_waddr(n_fwd_pending_waddr)
    );

    int total  = 0;
    int passed = 0;
    int failed = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: pick bytes out of a little-endian byte array, then extend.
    function automatic logic [63:0] ref_load(input int xlen, input logic [63:0] lo,
                                             input logic [63:0] hi, input int ofs,
                                             input int size, input bit uns);
        logic [7:0]  bytes [16];
        logic [63:0] v;
        int xb, nb;
        xb = xlen / 8;
        for (int i = 0; i < 16; i++) bytes[i] = 8'h00;
        for (int i = 0; i < xb; i++) begin
            bytes[i]      = lo[8*i +: 8];
            bytes[xb + i] = hi[8*i +: 8];
        end
        nb = 1 << size;
        if (nb > xb) nb = xb;
        v = 64'd0;
        for (int i = 0; i < nb; i++) v = v | (64'(bytes[ofs + i]) << (8 * i));
        if (!uns && nb < 8 && v[8*nb-1]) v = v | (~64'd0 << (8 * nb));
        if (xlen == 32) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    task automatic send64(input logic [63:0] rdata, input int ofs, input int size,
                          input bit uns, input bit ld, input bit split, input bit we,
                          input int waddr, input logic [63:0] ex, input logic [63:0] pc,
                          input logic [31:0] inst);
        int n = 0;
        in_rdata = rdata; in_offset = 3'(ofs); in_size = 2'(size); in_unsigned = uns;
        in_is_load = ld; in_split = split; in_rf_we = we; in_rf_waddr = 5'(waddr);
        in_ex_result = ex; in_pc = pc; in_inst = inst; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 20) begin step(); n++; end
        chk("accept_wait64", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic send32(input logic [31:0] rdata, input int ofs, input int size,
                          input bit uns, input bit ld, input bit split, input bit we,
                          input int waddr, input logic [31:0] ex, input logic [31:0] pc);
        int n = 0;
        n_in_rdata = rdata; n_in_offset = 2'(ofs); n_in_size = 2'(size);
        n_in_unsigned = uns; n_in_is_load = ld; n_in_split = split; n_in_rf_we = we;
        n_in_rf_waddr = 5'(waddr); n_in_ex_result = ex; n_in_pc = pc;
        n_in_inst = $urandom; n_in_valid = 1'b1;
        #1;
        while (!n_in_ready && n < 20) begin step(); n++; end
        chk("accept_wait32", {63'd0, n_in_ready}, 64'd1);
        step();
        n_in_valid = 1'b0;
    endtask

    task automatic chk_out64(input string tag, input logic [63:0] wdata, input bit we,
                             input int waddr, input logic [63:0] pc);
        bit exp_we;
        exp_we = we && (waddr != 0);
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_wdata"}, out_rf_wdata, wdata);
        chk({tag, "_we"}, {63'd0, out_rf_we}, {63'd0, exp_we});
        chk({tag, "_waddr"}, 64'(out_rf_waddr), 64'(waddr));
        chk({tag, "_pc"}, out_pc, pc);
        chk({tag, "_fwd_we"}, {63'd0, fwd_we}, {63'd0, exp_we});
    endtask

    initial begin
        logic [63:0] pc, lo, hi, ex, exp_v;
        int ofs, size, waddr, kind;
        bit uns, we;

        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_rdata = '0; in_offset = '0; in_size = '0; in_unsigned = 1'b0;
        in_is_load = 1'b0; in_split = 1'b0; in_rf_we = 1'b0; in_rf_waddr = '0;
        in_ex_result = '0; in_pc = '0; in_inst = '0;
        n_in_valid = 1'b0; n_in_rdata = '0; n_in_offset = '0; n_in_size = '0;
        n_in_unsigned = 1'b0; n_in_is_load = 1'b0; n_in_split = 1'b0; n_in_rf_we = 1'b0;
        n_in_rf_waddr = '0; n_in_ex_result = '0; n_in_pc = '0; n_in_inst = '0;
        step(); step();
        rst_n = 1'b1;
        step();

        // Reset state
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_we", {63'd0, out_rf_we}, 64'd0);
        chk("rst_waddr", 64'(out_rf_waddr), 64'd0);
        chk("rst_wdata", out_rf_wdata, 64'd0);
        chk("rst_pc", out_pc, 64'd0);
        chk("rst_inst", 64'(out_inst), 64'd0);
        chk("rst_fwd", {62'd0, fwd_we, fwd_pending}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_n_valid", {63'd0, n_out_valid}, 64'd0);

        // LB / LBU at offset 7
        send64(64'h8000_0000_0000_0000, 7, 0, 0, 1, 0, 1, 5, 64'd0, 64'h100, 32'h11);
        chk_out64("lb", 64'hFFFF_FFFF_FFFF_FF80, 1, 5, 64'h100);
        chk("lb_inst", 64'(out_inst), 64'h11);
        chk("lb_fwd_wdata", fwd_wdata, 64'hFFFF_FFFF_FFFF_FF80);
        send64(64'h8000_0000_0000_0000, 7, 0, 1, 1, 0, 1, 5, 64'd0, 64'h104, 32'h12);
        chk_out64("lbu", 64'h80, 1, 5, 64'h104);

        // Split LW at offset 6; hi-beat metadata is junk and must be ignored
        send64(64'hBBAA_0000_0000_0000, 6, 2, 0, 1, 1, 1, 9, 64'd0, 64'h200, 32'h21);
        chk("lw_pending", {63'd0, fwd_pending}, 64'd1);
        chk("lw_pending_waddr", 64'(fwd_pending_waddr), 64'd9);
        chk("lw_mid_valid", {63'd0, out_valid}, 64'd0);
        send64(64'h0000_0000_0000_DDCC, 0, 0, 1, 0, 0, 0, 3, 64'hDEAD, 64'h999, 32'h0);
        chk_out64("lw", 64'hFFFF_FFFF_DDCC_BBAA, 1, 9, 64'h200);
        chk("lw_inst", 64'(out_inst), 64'h21);
        chk("lw_pending_done", {63'd0, fwd_pending}, 64'd0);
        send64(64'hBBAA_0000_0000_0000, 6, 2, 1, 1, 1, 1, 9, 64'd0, 64'h204, 32'h22);
        send64(64'h0000_0000_0000_DDCC, 3, 1, 0, 1, 1, 1, 4, 64'd0, 64'h998, 32'h0);
        chk_out64("lwu", 64'h0000_0000_DDCC_BBAA, 1, 9, 64'h204);

        // Back-pressure: a queued beat waits while outputs hold
        out_ready = 1'b0;
        in_rdata = '0; in_offset = '0; in_size = '0; in_unsigned = 1'b0; in_is_load = 1'b0;
        in_split = 1'b0; in_rf_we = 1'b1; in_rf_waddr = 5'd7;
        in_ex_result = 64'h1234_5678_9ABC_DEF0; in_pc = 64'h300; in_inst = 32'h31;
        in_valid = 1'b1;
        step(); step();
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_wdata_hold", out_rf_wdata, 64'h0000_0000_DDCC_BBAA);
        chk("bp_pc_hold", out_pc, 64'h204);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk_out64("bp_release", 64'h1234_5678_9ABC_DEF0, 1, 7, 64'h300);
        step();
        chk("drain_valid", {63'd0, out_valid}, 64'd0);
        chk("drain_wdata_hold", out_rf_wdata, 64'h1234_5678_9ABC_DEF0);

        // Flush in WAIT_HI drops the lo buffer and the beat presented with it
        send64(64'hFFFF_FFFF_FFFF_FFFF, 4, 3, 0, 1, 1, 1, 12, 64'd0, 64'h400, 32'h41);
        chk("fl_pending", {63'd0, fwd_pending}, 64'd1);
        flush = 1'b1; in_valid = 1'b1; in_rdata = 64'hAAAA_AAAA_AAAA_AAAA;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_pending_clr", {63'd0, fwd_pending}, 64'd0);
        chk("fl_pending_waddr", 64'(fwd_pending_waddr), 64'd0);
        chk("fl_valid", {63'd0, out_valid}, 64'd0);
        send64(64'h1122_3344_5566_7788, 0, 3, 0, 1, 0, 1, 13, 64'd0, 64'h404, 32'h42);
        chk_out64("fl_ld", 64'h1122_3344_5566_7788, 1, 13, 64'h404);

        // Reset mid-split
        send64(64'h7777_0000_0000_0000, 6, 2, 0, 1, 1, 1, 14, 64'd0, 64'h500, 32'h51);
        chk("rs_pending", {63'd0, fwd_pending}, 64'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rs_valid", {63'd0, out_valid}, 64'd0);
        chk("rs_wdata", out_rf_wdata, 64'd0);
        chk("rs_pc", out_pc, 64'd0);
        chk("rs_waddr", 64'(out_rf_waddr), 64'd0);
        chk("rs_pending", {63'd0, fwd_pending}, 64'd0);
        chk("rs_pending_waddr", 64'(fwd_pending_waddr), 64'd0);
        send64(64'h0000_0000_0000_8001, 0, 1, 0, 1, 0, 1, 15, 64'd0, 64'h504, 32'h52);
        chk_out64("rs_fresh", 64'hFFFF_FFFF_FFFF_8001, 1, 15, 64'h504);

        // 32-bit instance directed
        send32(32'h8001_ABCD, 2, 1, 0, 1, 0, 1, 6, 32'd0, 32'h600);
        chk("n_lh_valid", {63'd0, n_out_valid}, 64'd1);
        chk("n_lh_wdata", 64'(n_out_rf_wdata), 64'hFFFF_8001);
        send32(32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1, 0, 32'h1234, 32'h604);
        chk("n_nl_wdata", 64'(n_out_rf_wdata), 64'h1234);
        chk("n_nl_we", {63'd0, n_out_rf_we}, 64'd0);
        chk("n_nl_fwd_we", {63'd0, n_fwd_we}, 64'd0);

        // Randomized transactions, 64-bit
        for (int it = 0; it < 150; it++) begin
            kind = int'($urandom_range(0, 2));
            lo = {$urandom, $urandom}; hi = {$urandom, $urandom}; ex = {$urandom, $urandom};
            pc = {$urandom, $urandom};
            ofs = int'($urandom_range(0, 7)); size = int'($urandom_range(0, 3));
            uns = 1'($urandom); we = 1'($urandom); waddr = int'($urandom_range(0, 31));
            if (kind == 0) begin
                send64(lo, ofs, size, uns, 0, 1'($urandom), we, waddr, ex, pc, $urandom);
                exp_v = ex;
            end else if (kind == 1) begin
                send64(lo, ofs, size, uns, 1, 0, we, waddr, ex, pc, $urandom);
                exp_v = ref_load(64, lo, 64'd0, ofs, size, uns);
            end else begin
                send64(lo, ofs, size, uns, 1, 1, we, waddr, ex, pc, $urandom);
                chk("r64_pending", {59'd0, fwd_pending, 5'(fwd_pending_waddr)},
                    {59'd0, 1'b1, 5'(waddr)});
                send64(hi, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                       1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       int'($urandom_range(0, 31)), ex, ~pc, $urandom);
                exp_v = ref_load(64, lo, hi, ofs, size, uns);
            end
            chk_out64("r64", exp_v, we, waddr, pc);
        end

        // Randomized transactions, 32-bit
        for (int it = 0; it < 60; it++) begin
            kind = int'($urandom_range(0, 2));
            lo = {32'd0, $urandom}; hi = {32'd0, $urandom}; ex = {32'd0, $urandom};
            ofs = int'($urandom_range(0, 3)); size = int'($urandom_range(0, 3));
            uns = 1'($urandom); we = 1'($urandom); waddr = int'($urandom_range(0, 31));
            if (kind == 0) begin
                send32(lo[31:0], ofs, size, uns, 0, 0, we, waddr, ex[31:0], 32'h700);
                exp_v = ex;
            end else if (kind == 1) begin
                send32(lo[31:0], ofs, size, uns, 1, 0, we, waddr, ex[31:0], 32'h700);
                exp_v = ref_load(32, lo, 64'd0, ofs, size, uns);
            end else begin
                send32(lo[31:0], ofs, size, uns, 1, 1, we, waddr, ex[31:0], 32'h700);
                chk("r32_pending", {63'd0, n_fwd_pending}, 64'd1);
                send32(hi[31:0], 0, 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       0, 32'd0, 32'h0);
                exp_v = ref_load(32, lo, hi, ofs, size, uns);
            end
            chk("r32_wdata", 64'(n_out_rf_wdata), exp_v);
            chk("r32_we", {63'd0, n_out_rf_we}, {63'd0, we && (waddr != 0)});
            chk("r32_waddr", 64'(n_out_rf_waddr), 64'(waddr));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
